// File: rtl/pipe_id_pkg.sv
// Shared pipeline definitions: opcode constants and small decode helpers used by the ID
// and EX stages.
package pipe_id_pkg;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpXori  = 6'h0E;
  localparam logic [5:0] OpLui   = 6'h0F;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam int unsigned NumRegs = 32;

  // Instructions that read rt as a source operand (not just as a destination).
  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OpRtype) || (op == OpSw) || (op == OpBeq) || (op == OpBne);
  endfunction

endpackage

// File: rtl/pipe_regfile.sv
// 32x32 register file, two combinational read ports and one write port; reads see a write
// issued in the same cycle. Register 0 always reads zero.
module pipe_regfile
  import pipe_id_pkg::*;
(
  input  logic        clk,
  input  logic        clrn,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b
);

  logic [31:0] regs_q [NumRegs];
  logic        wr_en;

  assign wr_en = we && (waddr != 5'd0);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < NumRegs; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[waddr] <= wdata;
    end
  end

  // Bypass is masked by reset so every output reads zero while clrn is low.
  always_comb begin
    rdata_a = regs_q[raddr_a];
    rdata_b = regs_q[raddr_b];
    if (clrn && wr_en && (waddr == raddr_a)) rdata_a = wdata;
    if (clrn && wr_en && (waddr == raddr_b)) rdata_b = wdata;
    if (raddr_a == 5'd0) rdata_a = '0;
    if (raddr_b == 5'd0) rdata_b = '0;
  end

endmodule

// File: rtl/pipe_id.sv
// Instruction-decode stage: IF/ID latch, field decode, immediate extension, register read
// and load-use hazard detection.
module pipe_id
  import pipe_id_pkg::*;
#(
  parameter logic [31:0] NOP_INST = 32'h00000000
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [31:0] newInst,
  input  logic [31:0] pc,
  input  logic        flush,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rd,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        stall,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [5:0]  id_op,
  output logic [5:0]  id_funct,
  output logic [4:0]  id_rs,
  output logic [4:0]  id_rt,
  output logic [4:0]  id_dst,
  output logic [31:0] id_a,
  output logic [31:0] id_b,
  output logic [31:0] id_imm
);

  logic [31:0] inst_q, pc_q;
  logic        valid_q;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      inst_q  <= NOP_INST;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (flush) begin
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
    end else if (!stall) begin
      inst_q  <= newInst;
      pc_q    <= pc;
      valid_q <= 1'b1;
    end
  end

  logic [15:0] imm16;

  assign id_op    = inst_q[31:26];
  assign id_rs    = inst_q[25:21];
  assign id_rt    = inst_q[20:16];
  assign id_funct = inst_q[5:0];
  assign id_pc    = pc_q;
  assign imm16    = inst_q[15:0];

  always_comb begin
    case (id_op)
      OpRtype: id_dst = inst_q[15:11];
      OpJal:   id_dst = 5'd31;
      default: id_dst = id_rt;
    endcase
  end

  always_comb begin
    case (id_op)
      OpAndi, OpOri, OpXori: id_imm = {16'h0000, imm16};
      OpLui:                 id_imm = {imm16, 16'h0000};
      default:               id_imm = {{16{imm16[15]}}, imm16};
    endcase
  end

  // Load in EX whose result a source operand here needs: hold ID one cycle, emit a bubble.
  assign stall = valid_q && ex_memread && (ex_rd != 5'd0) &&
                 ((ex_rd == id_rs) || (uses_rt(id_op) && (ex_rd == id_rt)));

  assign id_valid = valid_q && !stall;

  pipe_regfile u_regfile (
    .clk     (clk),
    .clrn    (clrn),
    .we      (wb_we),
    .waddr   (wb_rd),
    .wdata   (wb_data),
    .raddr_a (id_rs),
    .raddr_b (id_rt),
    .rdata_a (id_a),
    .rdata_b (id_b)
  );

endmodule

// File: tb/tb_pipe_id.sv
// Self-checking bench for pipe_id: directed scenarios plus randomized traffic compared
// against a behavioural model of the decode stage.
module tb_pipe_id;

  localparam logic [31:0] Nop = 32'h00000000;

  logic        clk = 1'b0;
  logic        clrn;
  logic [31:0] newInst, pc, wb_data;
  logic        flush, ex_memread, wb_we;
  logic [4:0]  ex_rd, wb_rd;
  logic        stall, id_valid;
  logic [31:0] id_pc, id_a, id_b, id_imm;
  logic [5:0]  id_op, id_funct;
  logic [4:0]  id_rs, id_rt, id_dst;

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  logic [31:0] m_inst, m_pc;
  bit          m_valid;
  logic [31:0] m_regs [32];

  always #5 clk = ~clk;

  pipe_id #(.NOP_INST(Nop)) dut (
    .clk(clk), .clrn(clrn), .newInst(newInst), .pc(pc), .flush(flush),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall(stall), .id_valid(id_valid), .id_pc(id_pc), .id_op(id_op), .id_funct(id_funct),
    .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst), .id_a(id_a), .id_b(id_b), .id_imm(id_imm)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_inst  = Nop;
    m_pc    = '0;
    m_valid = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
  endtask

  function automatic logic [31:0] m_read(input int r);
    if (r == 0) return 32'd0;
    if (wb_we && wb_rd == r) return wb_data;
    return m_regs[r];
  endfunction

  function automatic bit m_stall();
    int op, rs, rt;
    bit reads_rt;
    op = int'(m_inst[31:26]);
    rs = int'(m_inst[25:21]);
    rt = int'(m_inst[20:16]);
    reads_rt = (op == 'h00) || (op == 'h2B) || (op == 'h04) || (op == 'h05);
    return m_valid && ex_memread && ex_rd != 0 &&
           (ex_rd == rs || (reads_rt && ex_rd == rt));
  endfunction

  // Compare all outputs with the model, then advance DUT and model across one rising edge.
  task automatic tick();
    int op, imm, dst;
    logic [31:0] e_imm;
    bit st;
    #1;
    op  = int'(m_inst[31:26]);
    imm = int'(m_inst[15:0]);
    if (op == 'h0C || op == 'h0D || op == 'h0E) e_imm = imm;
    else if (op == 'h0F) e_imm = imm * 65536;
    else e_imm = (imm >= 32768) ? imm - 65536 : imm;
    if (op == 0) dst = int'(m_inst[15:11]);
    else if (op == 3) dst = 31;
    else dst = int'(m_inst[20:16]);
    st = m_stall();
    check_eq("stall", 32'(stall), 32'(st));
    check_eq("id_valid", 32'(id_valid), 32'(m_valid && !st));
    if (m_valid) check_eq("id_pc", id_pc, m_pc);
    check_eq("id_op", 32'(id_op), op);
    check_eq("id_funct", 32'(id_funct), 32'(m_inst[5:0]));
    check_eq("id_rs", 32'(id_rs), 32'(m_inst[25:21]));
    check_eq("id_rt", 32'(id_rt), 32'(m_inst[20:16]));
    check_eq("id_dst", 32'(id_dst), dst);
    check_eq("id_imm", id_imm, e_imm);
    check_eq("id_a", id_a, m_read(int'(m_inst[25:21])));
    check_eq("id_b", id_b, m_read(int'(m_inst[20:16])));
    @(posedge clk);
    if (wb_we && wb_rd != 0) m_regs[wb_rd] = wb_data;
    if (flush) begin
      m_inst  = Nop;
      m_valid = 0;
    end else if (!st) begin
      m_inst  = newInst;
      m_pc    = pc;
      m_valid = 1;
    end
    @(negedge clk);
  endtask

  task automatic fetch(input logic [31:0] inst, input logic [31:0] addr);
    newInst = inst;
    pc      = addr;
    tick();
    #1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [5:0] ops [11];
    logic [31:0] w;
    ops = '{6'h00, 6'h03, 6'h04, 6'h05, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h08};
    w = $urandom;
    w[31:26] = ops[$urandom_range(10)];
    w[25:21] = 5'($urandom_range(7));
    w[20:16] = 5'($urandom_range(7));
    w[15:11] = 5'($urandom_range(7));
    return w;
  endfunction

  initial begin
    clrn = 0; newInst = '0; pc = '0; flush = 0; ex_memread = 0; ex_rd = '0;
    wb_we = 0; wb_rd = '0; wb_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_stall", 32'(stall), 0);
    check_eq("rst_valid", 32'(id_valid), 0);
    check_eq("rst_pc", id_pc, 0);
    @(negedge clk);
    clrn = 1;

    // addi $1,$0,5 visible one cycle after fetch
    fetch(32'h2001_0005, 32'h0);
    check_eq("addi_valid", 32'(id_valid), 1);
    check_eq("addi_dst", 32'(id_dst), 1);
    check_eq("addi_imm", id_imm, 5);
    check_eq("addi_a", id_a, 0);

    // Write-back bypass, then readback, then write to $0 ignored
    fetch(32'h8C61_0000, 32'h4);
    wb_we = 1; wb_rd = 5'd3; wb_data = 32'hDEAD_BEEF;
    #1 check_eq("bypass_a", id_a, 32'hDEAD_BEEF);
    tick();
    wb_we = 0;
    #1 check_eq("readback_a", id_a, 32'hDEAD_BEEF);
    fetch(32'h8C01_0000, 32'h8);
    wb_we = 1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
    tick();
    wb_we = 0;
    #1 check_eq("reg0_zero", id_a, 0);

    // Load-use hazard on add $4,$2,$3
    fetch(32'h0043_2020, 32'hC);
    ex_memread = 1; ex_rd = 5'd2; newInst = 32'h2001_0005; pc = 32'h10;
    #1 check_eq("lu_stall", 32'(stall), 1);
    check_eq("lu_valid", 32'(id_valid), 0);
    tick();
    #1 check_eq("lu_hold_rs", 32'(id_rs), 2);
    check_eq("lu_hold_pc", id_pc, 32'hC);
    ex_memread = 0;
    #1 check_eq("lu_release_stall", 32'(stall), 0);
    check_eq("lu_release_valid", 32'(id_valid), 1);
    check_eq("lu_release_funct", 32'(id_funct), 32'h20);

    // Flush wins over stall
    ex_memread = 1; flush = 1;
    #1 check_eq("fl_stall_pre", 32'(stall), 1);
    tick();
    flush = 0; ex_memread = 0;
    #1 check_eq("fl_valid", 32'(id_valid), 0);
    check_eq("fl_op", 32'(id_op), 32'(Nop[31:26]));
    check_eq("fl_rs", 32'(id_rs), 32'(Nop[25:21]));

    // Immediate extension and jal destination
    fetch(32'h3401_8000, 32'h20);
    check_eq("ori_imm", id_imm, 32'h0000_8000);
    fetch(32'h2001_8000, 32'h24);
    check_eq("addi_neg_imm", id_imm, 32'hFFFF_8000);
    fetch(32'h3C01_1234, 32'h28);
    check_eq("lui_imm", id_imm, 32'h1234_0000);
    fetch(32'h0C00_0010, 32'h2C);
    check_eq("jal_dst", 32'(id_dst), 31);

    // Asynchronous reset mid-stream clears everything without a clock edge
    fetch(32'h8C61_0000, 32'h30);
    check_eq("pre_rst_a", id_a, 32'hDEAD_BEEF);
    #1 clrn = 0;
    #1 check_eq("arst_a", id_a, 0);
    check_eq("arst_valid", 32'(id_valid), 0);
    check_eq("arst_pc", id_pc, 0);
    check_eq("arst_op", 32'(id_op), 0);
    #1 clrn = 1;
    model_reset();
    fetch(32'h8C61_0000, 32'h0);
    check_eq("arst_reg3", id_a, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      newInst    = rand_inst();
      pc         = $urandom;
      flush      = ($urandom_range(9) == 0);
      ex_memread = ($urandom_range(2) == 0);
      ex_rd      = 5'($urandom_range(7));
      wb_we      = $urandom_range(1) == 1;
      wb_rd      = 5'($urandom_range(7));
      wb_data    = $urandom;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
